// File: rtl/flow_switch_sequencer.sv
// Break-before-make sequencer for the planar flow-switch fabric: accepts one route
// command, actuates valves with pneumatic settle delays, holds, closes, reports done.
module flow_switch_sequencer #(
  parameter int NUM_SW = 11,
  parameter int SETTLE = 16,
  parameter int HOLD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NUM_SW-1:0]     cmd_mask,
  input  logic [2*NUM_SW-1:0]   cmd_sel,
  input  logic [HOLD_W-1:0]     cmd_hold,
  input  logic                  abort,
  output logic [2*NUM_SW-1:0]   sw_sel,
  output logic [NUM_SW-1:0]     sw_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_SET, S_MAKE, S_HOLD, S_CLOSE, S_DONE, S_ABORT
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [NUM_SW-1:0]    mask_q;
  logic [2*NUM_SW-1:0]  sel_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [2*NUM_SW-1:0]  sel_msk;

  // Each switch owns a 2-bit select field; widen the latched mask to cover them.
  always_comb begin
    sel_msk = '0;
    for (int k = 0; k < NUM_SW; k++) sel_msk[2*k +: 2] = {2{mask_q[k]}};
  end

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sw_sel   <= '0;
      sw_en    <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort && state != S_IDLE && state != S_ABORT) begin
        sw_en <= '0;
        cnt   <= CW'(SETTLE - 1);
        state <= S_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            if (abort) begin
              sw_en <= '0;
            end else if (cmd_valid) begin
              if (cmd_mask == '0) begin
                err <= 1'b1;
              end else begin
                mask_q <= cmd_mask;
                sel_q  <= cmd_sel;
                hold_q <= cmd_hold;
                sw_en  <= sw_en & ~cmd_mask;
                cnt    <= CW'(SETTLE - 1);
                state  <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (cnt == '0) begin
              sw_sel <= (sw_sel & ~sel_msk) | (sel_q & sel_msk);
              state  <= S_SET;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_SET: begin
            sw_en <= sw_en | mask_q;
            cnt   <= CW'(SETTLE - 1);
            state <= S_MAKE;
          end
          S_MAKE: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (hold_q != '0) begin
              hold_cnt <= hold_q - HOLD_W'(1);
              state    <= S_HOLD;
            end else begin
              state <= S_DONE;
            end
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              sw_en <= sw_en & ~mask_q;
              cnt   <= CW'(SETTLE - 1);
              state <= S_CLOSE;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
          S_CLOSE: begin
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - CW'(1);
          end
          S_DONE: state <= S_IDLE;
          S_ABORT: begin
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - CW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flow_switch_sequencer.sv
// Bench for flow_switch_sequencer: timeline model built from the command latency
// rules, per-cycle comparison, plus directed scenarios with literal expectations.
module tb_flow_switch_sequencer;
  localparam int NUM_SW = 11;
  localparam int SETTLE = 16;
  localparam int HOLD_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 abort = 1'b0;
  logic [NUM_SW-1:0]    cmd_mask = '0;
  logic [2*NUM_SW-1:0]  cmd_sel = '0;
  logic [HOLD_W-1:0]    cmd_hold = '0;
  logic                 cmd_ready, busy, done, err;
  logic [2*NUM_SW-1:0]  sw_sel;
  logic [NUM_SW-1:0]    sw_en;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  flow_switch_sequencer #(.NUM_SW(NUM_SW), .SETTLE(SETTLE), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_sel(cmd_sel), .cmd_hold(cmd_hold), .abort(abort),
    .sw_sel(sw_sel), .sw_en(sw_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
  endtask

  // Model: a command accepted in cycle t0 is a list of timed events at fixed offsets.
  bit                   act = 1'b0, ab = 1'b0;
  int                   t0m = 0, ta = 0, mh = 0;
  logic [NUM_SW-1:0]    mm = '0, e_en = '0;
  logic [2*NUM_SW-1:0]  ms = '0, e_sel = '0;
  bit                   e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

  always @(posedge clk) begin
    int n, d, doff;
    bit idle;
    n = cyc + 1;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      act = 1'b0; ab = 1'b0; e_en = '0; e_sel = '0;
    end else begin
      idle = !act && !ab;
      if (!idle && abort && !ab) begin
        ab = 1'b1; act = 1'b0; ta = cyc; e_en = '0;
      end else if (idle) begin
        if (abort) e_en = '0;
        else if (cmd_valid) begin
          if (cmd_mask == '0) e_err = 1'b1;
          else begin
            act = 1'b1; t0m = cyc; mm = cmd_mask; ms = cmd_sel; mh = int'(cmd_hold);
          end
        end
      end
      if (act) begin
        d    = n - t0m;
        doff = (mh == 0) ? 2*SETTLE + 2 : 3*SETTLE + mh + 2;
        if (d == 1) e_en = e_en & ~mm;
        if (d == SETTLE + 1)
          for (int k = 0; k < NUM_SW; k++) if (mm[k]) e_sel[2*k +: 2] = ms[2*k +: 2];
        if (d == SETTLE + 2) e_en = e_en | mm;
        if (mh != 0 && d == 2*SETTLE + 2 + mh) e_en = e_en & ~mm;
        if (d == doff) e_done = 1'b1;
        if (d == doff + 1) act = 1'b0;
      end
      if (ab && n - ta == SETTLE + 1) ab = 1'b0;
    end
    e_busy = act || ab;
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {sw_en, sw_sel, busy, done, err, cmd_ready},
            {e_en, e_sel, e_busy, e_done, e_err, (!e_busy && !rst)});
  end

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
    if (cyc != n) check("schedule", 64'(cyc), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("ready_in_reset", cmd_ready, 0);
    check("busy_in_reset", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    check("en_after_reset", sw_en, 0);

    // Basic route: sw0->2, sw1->3, hold 5
    t0 = cyc; cmd_valid = 1'b1; cmd_mask = 11'h003; cmd_sel = 22'h00000E; cmd_hold = 16'd5;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    check("basic_busy", busy, 1);
    at_cyc(t0 + 16); check("basic_sel_pre", sw_sel, 0);
    at_cyc(t0 + 17); check("basic_sel", sw_sel, 22'h00000E);
    check("basic_en_set", sw_en, 0);
    at_cyc(t0 + 18); check("basic_en_make", sw_en, 11'h003);
    at_cyc(t0 + 38); check("basic_en_hold_end", sw_en, 11'h003);
    at_cyc(t0 + 39); check("basic_en_close", sw_en, 0);
    at_cyc(t0 + 54); check("basic_done_early", done, 0);
    at_cyc(t0 + 55); check("basic_done", done, 1);
    at_cyc(t0 + 56); check("basic_idle", {busy, cmd_ready}, 2'b01);

    // hold=0 leaves sw10 open; second command on sw0 must not disturb it
    at_cyc(t0 + 60); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = 11'h400; cmd_sel = 22'h100000; cmd_hold = 16'd0;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    at_cyc(t0 + 33); check("h0_done_early", done, 0);
    at_cyc(t0 + 34); check("h0_done", done, 1);
    at_cyc(t0 + 35); check("h0_en_open", sw_en, 11'h400);
    at_cyc(t0 + 36); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = 11'h001; cmd_sel = 22'h000003; cmd_hold = 16'd0;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    check("h0b_en_break", sw_en, 11'h400);
    at_cyc(t0 + 35);
    check("h0b_en", sw_en, 11'h401);
    check("h0b_sel", sw_sel, 22'h10000F);

    // Empty mask: err pulse, nothing else moves
    at_cyc(t0 + 38); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = '0; cmd_sel = 22'h3FFFFF; cmd_hold = 16'd9;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    check("empty_err", err, 1);
    check("empty_busy", busy, 0);
    check("empty_en", sw_en, 11'h401);
    at_cyc(t0 + 2); check("empty_err_clear", err, 0);

    // Abort during HOLD closes every valve, including sw0/sw10 left open earlier
    at_cyc(t0 + 4); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = 11'h010; cmd_sel = 22'h000200; cmd_hold = 16'd100;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    at_cyc(t0 + 40); check("ab_en_hold", sw_en, 11'h411); abort = 1'b1;
    at_cyc(t0 + 41); abort = 1'b0;
    check("ab_en", sw_en, 0);
    check("ab_sel", sw_sel, 22'h10020F);
    at_cyc(t0 + 56); check("ab_busy", {busy, cmd_ready}, 2'b10);
    at_cyc(t0 + 57); check("ab_ready", {busy, cmd_ready}, 2'b01);

    // Backpressure: valid held; second payload taken on first IDLE cycle after done
    at_cyc(t0 + 60); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = 11'h002; cmd_sel = 22'h000004; cmd_hold = 16'd3;
    at_cyc(t0 + 1); cmd_mask = 11'h004; cmd_sel = 22'h000010; cmd_hold = 16'd0;
    at_cyc(t0 + 20); check("bp_ready_busy", cmd_ready, 0);
    at_cyc(t0 + 53); check("bp_done_a", done, 1);
    at_cyc(t0 + 54); check("bp_ready_idle", cmd_ready, 1);
    at_cyc(t0 + 55); cmd_valid = 1'b0;
    check("bp_busy_b", busy, 1);
    at_cyc(t0 + 88); check("bp_done_b", done, 1);
    check("bp_en_b", sw_en, 11'h004);

    // Abort while idle closes valves immediately
    at_cyc(t0 + 90); abort = 1'b1;
    at_cyc(t0 + 91); abort = 1'b0;
    check("abidle_en", sw_en, 0);
    check("abidle_busy", busy, 0);

    // Reset in the middle of MAKE
    at_cyc(t0 + 93); t0 = cyc;
    cmd_valid = 1'b1; cmd_mask = 11'h008; cmd_sel = 22'h000080; cmd_hold = 16'd0;
    at_cyc(t0 + 1); cmd_valid = 1'b0;
    at_cyc(t0 + 20); check("rst_en_make", sw_en, 11'h008); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    at_cyc(t0 + 21);
    check("rst_en", sw_en, 0);
    check("rst_sel", sw_sel, 0);
    check("rst_state", {busy, done, cmd_ready}, 3'b001);
    at_cyc(t0 + 40); check("rst_no_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flow_switch_sequencer.md
Name: flow_switch_sequencer

Overview:
- Control-layer sequencer for the planar switch fabric: drives the valve select and enable lines of the 4-port flow switches that route Source inputs through Mixer/Heater/Filter stages to Out1.
- Accepts one route command at a time on a valid/ready interface, then runs a break-before-make actuation sequence with pneumatic settle delays.
- Holds the route open for a commanded duration, then closes it and reports completion.

Parameters:
- NUM_SW, 11, number of flow switches controlled; index 0 is flow_switch3_0, index k is flow_switch4_k.
- SETTLE, 16, cycles to wait after any valve enable change; must be ≥1.
- HOLD_W, 16, width of the hold-duration field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  route command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_mask  in  NUM_SW  switches affected by the command.
- cmd_sel  in  2*NUM_SW  target port per switch, 0..3; switch k uses bits [2k+1:2k].
- cmd_hold  in  HOLD_W  hold cycles; 0 means leave the route open.
- abort  in  1  close all valves and return to idle.
- sw_sel  out  2*NUM_SW  registered port select per switch.
- sw_en  out  NUM_SW  registered valve open per switch.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; sw_sel=0; sw_en=0; counters=0; done=0; err=0; busy=0; cmd_ready=0 during reset, 1 on the first cycle after reset. Reset mid-sequence takes effect in the same cycle and overrides abort.
- cmd_ready=1 only in IDLE.
- Accept: cmd_valid & cmd_ready at an edge; latch mask, sel and hold.
- Empty mask: the command is accepted and dropped. err pulses on the next cycle, the state stays IDLE, and no output changes.
- States:
  - IDLE: wait for a command.
  - BREAK: sw_en[k]←0 for every masked k, registered on the entry edge. Wait SETTLE cycles, counter SETTLE-1 down to 0.
  - SET: sw_sel field k←latched sel for masked k; unmasked fields keep their value. Lasts exactly 1 cycle.
  - MAKE: sw_en[k]←1 for masked k. Wait SETTLE cycles.
  - HOLD: count latched hold cycles down to 0. Entered only when hold≠0.
  - CLOSE: sw_en[k]←0 for masked k. Wait SETTLE cycles.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Transition order: IDLE→BREAK→SET→MAKE→(hold≠0: HOLD→CLOSE)→DONE→IDLE. With hold=0, MAKE→DONE directly and masked valves stay open after completion.
- Unmasked switches: sw_sel and sw_en are never modified by a command, so routes left open by earlier hold=0 commands persist.
- Latency: accept edge at cycle 0. BREAK occupies cycles 1..SETTLE, SET is SETTLE+1, MAKE is SETTLE+2..2·SETTLE+1.
  - hold=0: done at cycle 2·SETTLE+2.
  - hold=H: done at cycle 3·SETTLE+H+2.
- abort:
  - In any state other than IDLE or ABORT: all sw_en←0 (every switch), enter ABORT, wait SETTLE cycles, then IDLE. done and err are not pulsed.
  - In IDLE: all sw_en←0 immediately, state stays IDLE.
  - In ABORT: ignored; the counter does not restart.
- cmd_valid while busy has no effect; the command is not accepted and is not dropped.
- The hold counter is HOLD_W bits with no wrap; the maximum hold is 2^HOLD_W−1.
- done and err are never high in the same cycle.

Test Plan:
- Basic route, SETTLE=16: mask=0x003, sel sw0=2, sw1=3, hold=5 → sw_en[1:0]=11 during cycles 18..38, sw_sel=0x0E from cycle 17, done at cycle 55, sw_en=0 afterwards.
- hold=0: mask=0x400, sel sw10=1 → done at cycle 34, sw_en[10] stays 1. A second command with mask=0x001 leaves sw_en[10]=1 and sw_sel[21:20]=01.
- Empty mask: mask=0 with cmd_valid → err pulse one cycle after accept, busy stays 0, outputs unchanged.
- Abort in HOLD: hold=100, abort at cycle 40 → all sw_en=0 at cycle 41, busy until cycle 56, no done pulse, cmd_ready=1 at cycle 57.
- Backpressure: cmd_valid held through a sequence → cmd_ready=0 while busy, and the second command is accepted on the first IDLE cycle after done.
- Reset mid-MAKE: rst at cycle 20 → next cycle sw_en=0, sw_sel=0, busy=0, and no done pulse.
